// File: rtl/ssg_pkg.sv
// rtl/ssg_pkg.sv - shared glyphs, constants, FSM encoding and helpers for the 7-segment controller
package ssg_pkg;

    // Active-low {a,b,c,d,e,f,g,dp}; index = nibble value, dp bit left off
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/ssg_bin2bcd.sv
// rtl/ssg_bin2bcd.sv - iterative double-dabble binary to BCD converter, one bit per clock
module ssg_bin2bcd
    import ssg_pkg::*;
#(
    parameter int VAL_W    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VAL_W-1:0]        bin,
    output logic                    done,
    output logic [4*N_DIGITS-1:0]   bcd
);

    // One spare nibble so the add-3 never loses a carry; it is dropped on output
    localparam int BCD_W = 4*N_DIGITS + 4;
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [BCD_W-1:0]       bcd_q;
    logic [VAL_W-1:0]       bin_q;
    logic [CNT_W-1:0]       cnt;
    logic [BCD_W-1:0]       adj;
    logic [BCD_W+VAL_W-1:0] shifted;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < N_DIGITS + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt   <= '0;
        end else if (start) begin
            bcd_q <= '0;
            bin_q <= bin;
            cnt   <= CNT_W'(VAL_W);
        end else if (cnt != '0) begin
            {bcd_q, bin_q} <= shifted;
            cnt            <= cnt - CNT_W'(1);
        end
    end

    // High during the cycle whose closing edge performs the final shift
    assign done = (cnt == CNT_W'(1));
    assign bcd  = bcd_q[4*N_DIGITS-1:0];

endmodule

// File: rtl/ssg_display_ctrl.sv
// rtl/ssg_display_ctrl.sv - load handshake, display register and multiplexed 7-segment scan
module ssg_display_ctrl
    import ssg_pkg::*;
#(
    parameter int VAL_W      = 14,
    parameter int N_DIGITS   = 4,
    parameter int PRESC_BITS = 18
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    input  logic                  mode_hex,
    input  logic                  blank_lz,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic                  ready,
    output logic                  overflow,
    output logic [7:0]            LED_out,
    output logic [N_DIGITS-1:0]   Anode_Activate
);

    localparam int         IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int         HEX_W     = 4*N_DIGITS;
    localparam logic [63:0] DEC_LIMIT = pow10(N_DIGITS);

    logic [1:0]                  state;
    logic [VAL_W-1:0]            value_q;
    logic                        mode_q;
    logic                        blank_q;
    logic [N_DIGITS-1:0]         dp_q;
    logic                        ovf_pend;

    logic [N_DIGITS-1:0][3:0]    disp;
    logic [N_DIGITS-1:0]         disp_dp;
    logic [N_DIGITS-1:0]         disp_blank;

    logic [PRESC_BITS-1:0]       presc;
    logic [IDX_W-1:0]            idx;

    logic                        conv_start;
    logic                        conv_last;
    logic [HEX_W-1:0]            bcd;
    logic [HEX_W-1:0]            hex_src;
    logic [N_DIGITS-1:0][3:0]    src_nib;
    logic [N_DIGITS-1:0]         src_blank;
    logic                        ovf_dec;
    logic                        ovf_hex;
    logic                        seen_nz;
    logic [7:0]                  glyph_cur;
    logic [N_DIGITS-1:0]         onehot;

    assign conv_start = (state == ST_CAPTURE) && !mode_q;

    ssg_bin2bcd #(
        .VAL_W    (VAL_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clock_50Mhz (clock_50Mhz),
        .reset       (reset),
        .start       (conv_start),
        .bin         (value_q),
        .done        (conv_last),
        .bcd         (bcd)
    );

    assign ovf_dec = 64'(value_q) >= DEC_LIMIT;
    assign ovf_hex = (value_q >> HEX_W) != '0;
    assign hex_src = HEX_W'(value_q);

    // Digit 0 is the most significant nibble of the source word
    always_comb begin
        src_nib   = '0;
        src_blank = '0;
        seen_nz   = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            src_nib[i] = mode_q ? hex_src[4*(N_DIGITS-1-i) +: 4] : bcd[4*(N_DIGITS-1-i) +: 4];
            if (src_nib[i] != 4'd0) begin
                seen_nz = 1'b1;
            end
            src_blank[i] = blank_q && !seen_nz && (i != N_DIGITS-1);
        end
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            overflow   <= 1'b0;
            value_q    <= '0;
            mode_q     <= 1'b0;
            blank_q    <= 1'b0;
            dp_q       <= '0;
            ovf_pend   <= 1'b0;
            disp       <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready && load) begin
                        value_q <= value;
                        mode_q  <= mode_hex;
                        blank_q <= blank_lz;
                        dp_q    <= dp_mask;
                        ready   <= 1'b0;
                        state   <= ST_CAPTURE;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    ovf_pend <= mode_q ? ovf_hex : ovf_dec;
                    state    <= mode_q ? ST_COMMIT : ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (conv_last) begin
                        state <= ST_COMMIT;
                    end
                end
                default: begin
                    disp       <= src_nib;
                    disp_dp    <= dp_q;
                    disp_blank <= src_blank;
                    overflow   <= ovf_pend;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        if (overflow) begin
            glyph_cur = SEG_DASH;
        end else if (disp_blank[idx]) begin
            glyph_cur = SEG_BLANK;
        end else begin
            glyph_cur = seg_encode(disp[idx]) & {7'h7F, ~disp_dp[idx]};
        end
        onehot = '0;
        onehot[IDX_W'(N_DIGITS-1) - idx] = 1'b1;
    end

    // Outputs latch the digit being left as the index advances
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            presc          <= '0;
            idx            <= '0;
            LED_out        <= SEG_BLANK;
            Anode_Activate <= '1;
        end else begin
            presc <= presc + PRESC_BITS'(1);
            if (&presc) begin
                idx            <= (idx == IDX_W'(N_DIGITS-1)) ? '0 : idx + IDX_W'(1);
                LED_out        <= glyph_cur;
                Anode_Activate <= ~onehot;
            end
        end
    end

endmodule

// File: tb/tb_ssg_display_ctrl.sv
// tb/tb_ssg_display_ctrl.sv - randomized self-checking bench with a behavioural display model
module tb_ssg_display_ctrl;

    logic        clock_50Mhz = 1'b0;
    logic        reset       = 1'b1;
    logic [13:0] value       = '0;
    logic        load        = 1'b0;
    logic        mode_hex    = 1'b0;
    logic        blank_lz    = 1'b0;
    logic [3:0]  dp_mask     = '0;
    logic        ready;
    logic        overflow;
    logic [7:0]  LED_out;
    logic [3:0]  Anode_Activate;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clock_50Mhz = ~clock_50Mhz;

    ssg_display_ctrl #(
        .VAL_W      (14),
        .N_DIGITS   (4),
        .PRESC_BITS (2)
    ) dut (
        .clock_50Mhz    (clock_50Mhz),
        .reset          (reset),
        .value          (value),
        .load           (load),
        .mode_hex       (mode_hex),
        .blank_lz       (blank_lz),
        .dp_mask        (dp_mask),
        .ready          (ready),
        .overflow       (overflow),
        .LED_out        (LED_out),
        .Anode_Activate (Anode_Activate)
    );

    logic [7:0] glyph_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                   8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    int p10 [4] = '{1000, 100, 10, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_ovf(input int v, input bit hex);
        return hex ? (v >= 65536) : (v >= 10000);
    endfunction

    // Byte for digit i lives at [8*(3-i) +: 8], so digit 0 reads as the top byte
    function automatic logic [31:0] model_bytes(input int v, input bit hex, input bit blk, input logic [3:0] dp);
        logic [31:0] b;
        bit seen;
        int d;
        b = '0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = hex ? (v >> (4*(3-i))) % 16 : (v / p10[i]) % 10;
            if (d != 0) seen = 1'b1;
            if (model_ovf(v, hex)) b[8*(3-i) +: 8] = 8'hFD;
            else if (blk && !seen && i != 3) b[8*(3-i) +: 8] = 8'hFF;
            else b[8*(3-i) +: 8] = glyph_tab[d] & (dp[i] ? 8'hFE : 8'hFF);
        end
        return b;
    endfunction

    int          k;
    int          widx;
    int          m_rdy;
    int          m_commit;
    bit          m_ready;
    bit          rdy_old;
    bit          m_ovf;
    bit          m_pend_ovf;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    logic [7:0]  m_led;
    logic [3:0]  m_an;
    bit          s_reset = 1'b1;
    bit          s_load;
    bit          s_hex;
    bit          s_blank;
    logic [13:0] s_value;
    logic [3:0]  s_dp;

    initial begin : model_chk
        forever begin
            @(negedge clock_50Mhz);
            if (reset) begin
                k = 0; m_ready = 1'b1; m_rdy = 0; m_commit = 0;
                m_disp = 32'h03030303; m_ovf = 1'b0; m_led = 8'hFF; m_an = 4'hF;
            end else if (!s_reset) begin
                k++;
                if (k % 4 == 0) begin
                    widx  = (k/4 - 1) % 4;
                    m_led = m_disp[8*(3-widx) +: 8];
                    m_an  = ~(4'b1000 >> widx);
                end
                rdy_old = m_ready;
                if (m_commit > 0) begin
                    m_commit--;
                    if (m_commit == 0) begin
                        m_disp = m_pend;
                        m_ovf  = m_pend_ovf;
                    end
                end
                if (m_rdy > 0) begin
                    m_rdy--;
                    if (m_rdy == 0) m_ready = 1'b1;
                end
                if (rdy_old && s_load) begin
                    m_ready    = 1'b0;
                    m_rdy      = s_hex ? 3 : 17;
                    m_commit   = s_hex ? 2 : 16;
                    m_pend     = model_bytes(int'(s_value), s_hex, s_blank, s_dp);
                    m_pend_ovf = model_ovf(int'(s_value), s_hex);
                end
            end
            check("ready", {31'd0, ready}, {31'd0, m_ready});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("LED_out", {24'd0, LED_out}, {24'd0, m_led});
            check("Anode", {28'd0, Anode_Activate}, {28'd0, m_an});
            s_reset = reset; s_load = load; s_hex = mode_hex;
            s_blank = blank_lz; s_value = value; s_dp = dp_mask;
        end
    end

    task automatic do_load(input int v, input bit hex, input bit blk, input logic [3:0] dp);
        @(posedge clock_50Mhz); #1;
        value = 14'(v); mode_hex = hex; blank_lz = blk; dp_mask = dp; load = 1'b1;
        @(posedge clock_50Mhz); #1;
        load = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clock_50Mhz); #1;
            n++;
        end
        if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic capture(output logic [31:0] got);
        got = '0;
        repeat (20) begin
            @(negedge clock_50Mhz);
            case (Anode_Activate)
                4'b0111: got[31:24] = LED_out;
                4'b1011: got[23:16] = LED_out;
                4'b1101: got[15:8]  = LED_out;
                4'b1110: got[7:0]   = LED_out;
                default: ;
            endcase
        end
    endtask

    int          lat;
    logic [31:0] got;

    initial begin : driver
        repeat (3) @(posedge clock_50Mhz);
        #1 reset = 1'b0;
        @(negedge clock_50Mhz);
        check("rst_led", {24'd0, LED_out}, 32'hFF);
        check("rst_anode", {28'd0, Anode_Activate}, 32'hF);
        check("rst_ready", {31'd0, ready}, 32'd1);
        repeat (4) @(posedge clock_50Mhz);
        @(negedge clock_50Mhz);
        check("wrap1_anode", {28'd0, Anode_Activate}, 32'h7);
        check("wrap1_led", {24'd0, LED_out}, 32'h03);

        do_load(1234, 1'b0, 1'b0, 4'b0000);
        wait_ready(lat);
        check("lat_dec", lat, 17);
        capture(got);
        check("scan_1234", got, 32'h9F250D99);

        do_load(42, 1'b0, 1'b1, 4'b0100);
        wait_ready(lat);
        capture(got);
        check("scan_42_dp", got, 32'hFFFF9825);

        do_load(0, 1'b0, 1'b1, 4'b0000);
        wait_ready(lat);
        capture(got);
        check("scan_zero", got, 32'hFFFFFF03);

        do_load(14'h3ABF, 1'b1, 1'b0, 4'b0000);
        wait_ready(lat);
        check("lat_hex", lat, 3);
        capture(got);
        check("scan_hex", got, 32'h0D11C171);

        do_load(10000, 1'b0, 1'b0, 4'b1111);
        wait_ready(lat);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        capture(got);
        check("scan_ovf", got, 32'hFDFDFDFD);

        do_load(7, 1'b0, 1'b0, 4'b0000);
        wait_ready(lat);
        check("ovf_clear", {31'd0, overflow}, 32'd0);
        capture(got);
        check("scan_7", got, 32'h0303031F);

        do_load(5678, 1'b0, 1'b0, 4'b0000);
        repeat (4) begin @(posedge clock_50Mhz); #1; end
        value = 14'd999; load = 1'b1;
        @(posedge clock_50Mhz); #1;
        load = 1'b0;
        wait_ready(lat);
        check("lat_ignored_load", lat, 12);
        capture(got);
        check("scan_5678", got, 32'h49411F01);

        do_load(4321, 1'b0, 1'b0, 4'b0000);
        repeat (8) begin @(posedge clock_50Mhz); #1; end
        reset = 1'b1;
        @(negedge clock_50Mhz);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_led", {24'd0, LED_out}, 32'hFF);
        @(posedge clock_50Mhz); #1;
        reset = 1'b0;
        capture(got);
        check("scan_after_rst", got, 32'h03030303);

        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 4)) @(posedge clock_50Mhz);
            do_load(($urandom_range(0, 3) == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 18)) begin @(posedge clock_50Mhz); #1; end
                value = 14'($urandom_range(0, 16383)); load = 1'b1;
                @(posedge clock_50Mhz); #1;
                load = 1'b0;
            end
            wait_ready(lat);
            if ($urandom_range(0, 4) == 0) repeat (16) @(posedge clock_50Mhz);
        end

        repeat (20) @(posedge clock_50Mhz);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
